// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode-to-execute pipeline register with load-use
// hazard detection, bubble insertion and a saturating bubble count.
module id_ex_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_src,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_uses_dest,
  input  logic [DATA_W-1:0] id_src_val,
  input  logic [DATA_W-1:0] id_dest_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_wb,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_src,
  output logic [REG_W-1:0]  ex_dest,
  output logic [DATA_W-1:0] ex_src_val,
  output logic [DATA_W-1:0] ex_dest_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [3:0]        ex_alu_op,
  output logic              ex_wb,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              id_stall,
  output logic              load_use_hz,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  src;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] dest_val;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic              wb;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  id_ex_t           dec;
  id_ex_t           ex_q;
  id_ex_t           ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             src_hit;
  logic             dest_hit;
  logic             do_flush;
  logic             do_hold;
  logic             do_bub;

  // Control bits are gated so an invalid slot can never write back.
  always_comb begin
    dec           = '0;
    dec.valid     = id_valid;
    dec.src       = id_src;
    dec.dest      = id_dest;
    dec.src_val   = id_src_val;
    dec.dest_val  = id_dest_val;
    dec.imm       = id_imm;
    dec.alu_op    = id_alu_op;
    dec.wb        = id_wb & id_valid;
    dec.mem_read  = id_mem_read & id_valid;
    dec.mem_write = id_mem_write & id_valid;
  end

  assign src_hit  = id_src == ex_q.dest;
  assign dest_hit = id_uses_dest
                  & (id_dest == ex_q.dest);

  assign load_use_hz = ex_q.valid
                     & ex_q.mem_read
                     & ex_q.wb
                     & id_valid
                     & (src_hit | dest_hit);

  assign id_stall = ~flush
                  & (ex_stall | load_use_hz);

  // One-hot action selects; flush outranks stall outranks hazard.
  assign do_flush = flush;
  assign do_hold  = ~flush & ex_stall;
  assign do_bub   = ~flush & ~ex_stall
                  & load_use_hz;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      do_flush: ex_d = '0;
      do_hold:  ex_d = ex_q;
      do_bub: begin
        ex_d = '0;
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end
      default:  ex_d = dec;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_src       = ex_q.src;
  assign ex_dest      = ex_q.dest;
  assign ex_src_val   = ex_q.src_val;
  assign ex_dest_val  = ex_q.dest_val;
  assign ex_imm       = ex_q.imm;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_wb        = ex_q.wb;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign bubble_cnt   = cnt_q;

endmodule
